// File: rtl/traffic_phase_timer_if.sv
// Control/status bundle between the light sequencer (master) and the phase timer (slave).
// CNT_W must match the timer instance it is connected to.
interface traffic_phase_timer_if #(
   parameter int CNT_W = 16
);
   logic             enable;
   logic             ped_req;
   logic             emerg;
   logic [1:0]       phase;
   logic             phase_adv;
   logic             all_red;
   logic             ped_ack;
   logic [CNT_W-1:0] remaining;

   modport master (
      output enable, ped_req, emerg,
      input  phase, phase_adv, all_red, ped_ack, remaining
   );

   modport slave (
      input  enable, ped_req, emerg,
      output phase, phase_adv, all_red, ped_ack, remaining
   );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer for the 4-way light controller: green/yellow/all-red sequencing with
// pedestrian-extended W/S green and an emergency all-red hold.
module traffic_phase_timer #(
   parameter int CNT_W       = 16,
   parameter int GREEN_CYC   = 50,
   parameter int YELLOW_CYC  = 10,
   parameter int ALLRED_CYC  = 2,
   parameter int PED_EXT_CYC = 20
) (
   input logic                  clk,
   input logic                  reset_n,
   traffic_phase_timer_if.slave bus
);

   localparam logic [2:0] S_GREEN_A  = 3'd0;
   localparam logic [2:0] S_YELLOW_A = 3'd1;
   localparam logic [2:0] S_ALLRED_A = 3'd2;
   localparam logic [2:0] S_GREEN_B  = 3'd3;
   localparam logic [2:0] S_YELLOW_B = 3'd4;
   localparam logic [2:0] S_ALLRED_B = 3'd5;
   localparam logic [2:0] S_EMERG    = 3'd6;

   localparam logic [CNT_W-1:0] LD_GREEN     = CNT_W'(GREEN_CYC - 1);
   localparam logic [CNT_W-1:0] LD_GREEN_PED = CNT_W'(GREEN_CYC + PED_EXT_CYC - 1);
   localparam logic [CNT_W-1:0] LD_YELLOW    = CNT_W'(YELLOW_CYC - 1);
   localparam logic [CNT_W-1:0] LD_ALLRED    = CNT_W'(ALLRED_CYC - 1);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [1:0]       phase_q, phase_d;
   logic             adv_q, adv_d;
   logic             all_red_q, all_red_d;
   logic             ack_q, ack_d;
   logic             pend_q, pend_d;

   assign bus.phase     = phase_q;
   assign bus.phase_adv = adv_q;
   assign bus.all_red   = all_red_q;
   assign bus.ped_ack   = ack_q;
   assign bus.remaining = cnt_q;

   // Emergency outranks enable; EMERG freezes the counter and leaves only once enabled with emerg low.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      phase_d   = phase_q;
      adv_d     = 1'b0;
      all_red_d = all_red_q;
      ack_d     = 1'b0;
      pend_d    = pend_q | bus.ped_req;

      if (state_q > S_EMERG) begin
         state_d   = S_GREEN_A;
         cnt_d     = LD_GREEN;
         phase_d   = 2'd0;
         all_red_d = 1'b0;
         pend_d    = 1'b0;
      end else if (bus.emerg) begin
         state_d   = S_EMERG;
         all_red_d = 1'b1;
      end else if (bus.enable) begin
         if (state_q == S_EMERG) begin
            state_d   = S_ALLRED_B;
            cnt_d     = LD_ALLRED;
            phase_d   = 2'd3;
            all_red_d = 1'b1;
         end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
         end else begin
            case (state_q)
               S_GREEN_A: begin
                  state_d = S_YELLOW_A;
                  cnt_d   = LD_YELLOW;
                  phase_d = 2'd1;
                  adv_d   = 1'b1;
               end
               S_YELLOW_A: begin
                  state_d   = S_ALLRED_A;
                  cnt_d     = LD_ALLRED;
                  all_red_d = 1'b1;
               end
               S_ALLRED_A: begin
                  // A request arriving on this very edge is served now rather than next cycle.
                  state_d   = S_GREEN_B;
                  phase_d   = 2'd2;
                  adv_d     = 1'b1;
                  all_red_d = 1'b0;
                  if (pend_q | bus.ped_req) begin
                     cnt_d  = LD_GREEN_PED;
                     ack_d  = 1'b1;
                     pend_d = 1'b0;
                  end else begin
                     cnt_d  = LD_GREEN;
                  end
               end
               S_GREEN_B: begin
                  state_d = S_YELLOW_B;
                  cnt_d   = LD_YELLOW;
                  phase_d = 2'd3;
                  adv_d   = 1'b1;
               end
               S_YELLOW_B: begin
                  state_d   = S_ALLRED_B;
                  cnt_d     = LD_ALLRED;
                  all_red_d = 1'b1;
               end
               S_ALLRED_B: begin
                  state_d   = S_GREEN_A;
                  cnt_d     = LD_GREEN;
                  phase_d   = 2'd0;
                  adv_d     = 1'b1;
                  all_red_d = 1'b0;
               end
               default: begin
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_GREEN_A;
         cnt_q     <= LD_GREEN;
         phase_q   <= 2'd0;
         adv_q     <= 1'b0;
         all_red_q <= 1'b0;
         ack_q     <= 1'b0;
         pend_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         phase_q   <= phase_d;
         adv_q     <= adv_d;
         all_red_q <= all_red_d;
         ack_q     <= ack_d;
         pend_q    <= pend_d;
      end
   end

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Scoreboard bench for traffic_phase_timer: a schedule-level reference model predicts every
// cycle's outputs into a queue, and an independent monitor pops and compares them.
module tb_traffic_phase_timer;

   localparam int CNT_W = 16;
   localparam int G     = 4;
   localparam int Y     = 2;
   localparam int A     = 1;
   localparam int P     = 3;

   logic clk = 1'b0;
   logic reset_n;

   traffic_phase_timer_if #(.CNT_W(CNT_W)) bus ();

   traffic_phase_timer #(
      .CNT_W(CNT_W), .GREEN_CYC(G), .YELLOW_CYC(Y), .ALLRED_CYC(A), .PED_EXT_CYC(P)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]       phase;
      logic             allRed;
      logic             adv;
      logic             ack;
      logic [CNT_W-1:0] rem;
   } expT;

   expT expQ[$];
   int  nChecks = 0;
   int  nErrors = 0;

   // The light schedule as a table of intervals: phase shown, all-red flag, length, and whether entry is a phase advance.
   int seqPhase[6] = '{0, 1, 1, 2, 3, 3};
   int seqRed[6]   = '{0, 0, 1, 0, 0, 1};
   int seqDur[6]   = '{G, Y, A, G, Y, A};
   int seqAdv[6]   = '{1, 1, 0, 1, 1, 0};

   int mIdx, mLeft, mPhase;
   bit mEmerg, mPend, mRed, mAdv, mAck;

   function automatic void modelReset();
      mIdx   = 0;
      mLeft  = G;
      mPhase = 0;
      mRed   = 1'b0;
      mAdv   = 1'b0;
      mAck   = 1'b0;
      mPend  = 1'b0;
      mEmerg = 1'b0;
   endfunction

   function automatic void modelStep(input bit en, input bit ped, input bit em);
      mAdv  = 1'b0;
      mAck  = 1'b0;
      mPend = mPend | ped;
      if (em) begin
         mEmerg = 1'b1;
         mRed   = 1'b1;
      end else if (!en) begin
      end else if (mEmerg) begin
         mEmerg = 1'b0;
         mIdx   = 5;
         mLeft  = A;
         mPhase = seqPhase[5];
         mRed   = 1'b1;
      end else begin
         mLeft = mLeft - 1;
         if (mLeft == 0) begin
            mIdx   = (mIdx + 1) % 6;
            mLeft  = seqDur[mIdx];
            mPhase = seqPhase[mIdx];
            mRed   = (seqRed[mIdx] != 0);
            mAdv   = (seqAdv[mIdx] != 0);
            if (mIdx == 3 && mPend) begin
               mLeft = mLeft + P;
               mAck  = 1'b1;
               mPend = 1'b0;
            end
         end
      end
   endfunction

   function automatic expT modelExp();
      expT e;
      e.phase  = 2'(mPhase);
      e.allRed = mRed;
      e.adv    = mAdv;
      e.ack    = mAck;
      e.rem    = CNT_W'(mLeft - 1);
      return e;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nErrors++;
         $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, ".phase"},     32'(bus.phase),     32'd0);
      checkOutput({tag, ".all_red"},   32'(bus.all_red),   32'd0);
      checkOutput({tag, ".phase_adv"}, 32'(bus.phase_adv), 32'd0);
      checkOutput({tag, ".ped_ack"},   32'(bus.ped_ack),   32'd0);
      checkOutput({tag, ".remaining"}, 32'(bus.remaining), 32'(G - 1));
   endtask

   // Called aligned to a falling edge; drives one cycle and returns at the next falling edge.
   task automatic applyStimulus(input bit en, input bit ped, input bit em);
      bus.enable  = en;
      bus.ped_req = ped;
      bus.emerg   = em;
      modelStep(en, ped, em);
      expQ.push_back(modelExp());
      @(negedge clk);
   endtask

   task automatic applyAsyncReset();
      #2;
      reset_n     = 1'b0;
      bus.ped_req = 1'b0;
      bus.emerg   = 1'b0;
      #1;
      checkResetValues("asyncReset");
      modelReset();
      expQ.push_back(modelExp());
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("remAfterRelease", 32'(bus.remaining), 32'(G - 1));
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            expT e;
            e = expQ.pop_front();
            checkOutput("phase",     32'(bus.phase),     32'(e.phase));
            checkOutput("all_red",   32'(bus.all_red),   32'(e.allRed));
            checkOutput("phase_adv", 32'(bus.phase_adv), 32'(e.adv));
            checkOutput("ped_ack",   32'(bus.ped_ack),   32'(e.ack));
            checkOutput("remaining", 32'(bus.remaining), 32'(e.rem));
         end
      end
   end

   initial begin
      int emergLeft;
      reset_n     = 1'b0;
      bus.enable  = 1'b0;
      bus.ped_req = 1'b0;
      bus.emerg   = 1'b0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
      reset_n = 1'b1;
      modelReset();

      // Two clean periods of the nominal schedule.
      repeat (28) applyStimulus(1'b1, 1'b0, 1'b0);

      // Pause enable mid GREEN_A while two cycles remain.
      for (int k = 0; k < 20 && !(mIdx == 0 && mLeft == 3 && !mEmerg); k++) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
      repeat (4) applyStimulus(1'b1, 1'b0, 1'b0);

      // Single-cycle pedestrian pulse during GREEN_A, then two full periods.
      for (int k = 0; k < 20 && mIdx != 0; k++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (32) applyStimulus(1'b1, 1'b0, 1'b0);

      // Three-cycle emergency during YELLOW_A.
      for (int k = 0; k < 20 && mIdx != 1; k++) applyStimulus(1'b1, 1'b0, 1'b0);
      repeat (3) applyStimulus(1'b1, 1'b0, 1'b1);
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);

      // Asynchronous reset while in GREEN_B.
      for (int k = 0; k < 20 && mIdx != 3; k++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyAsyncReset();
      repeat (6) applyStimulus(1'b1, 1'b0, 1'b0);

      // Pedestrian request and emergency together on the GREEN_B entry edge.
      for (int k = 0; k < 20 && !(mIdx == 2 && mLeft == 1 && !mEmerg); k++) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b1, 1'b1);
      repeat (30) applyStimulus(1'b1, 1'b0, 1'b0);

      // Randomized traffic: mostly enabled, sporadic requests, emergencies and resets.
      emergLeft = 0;
      for (int c = 0; c < 3000; c++) begin
         bit en, ped, em;
         en  = ($urandom_range(0, 9) != 0);
         ped = ($urandom_range(0, 14) == 0);
         if (emergLeft > 0) begin
            em = 1'b1;
            emergLeft--;
         end else if ($urandom_range(0, 59) == 0) begin
            em = 1'b1;
            emergLeft = $urandom_range(0, 3);
         end else begin
            em = 1'b0;
         end
         if ($urandom_range(0, 499) == 0) applyAsyncReset();
         else applyStimulus(en, ped, em);
      end

      for (int k = 0; k < 5 && expQ.size() > 0; k++) @(negedge clk);
      checkOutput("scoreboardDrain", 32'(expQ.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
